// File: rtl/riscv_uart_pkg.sv
// Shared UART register map and scheduler state encoding.
// riscv_uart and its transmit scheduler both import this package so the
// register addresses live in exactly one place.
package riscv_uart_pkg;

    localparam logic [11:0] UART_TX_ADDR   = 12'h004;
    localparam logic [11:0] UART_STAT_ADDR = 12'h008;
    localparam int          TX_BUSY_BIT    = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_POLL,
        ST_CHECK
    } tx_sched_state_t;

endpackage

// File: rtl/riscv_uart_tx_sched_if.sv
// Requester handshake plus the riscv_uart single-cycle register bus.
// master = the scheduler, slave = requesters and the UART side.
interface riscv_uart_tx_sched_if #(
    parameter int N    = 2,
    parameter int XLEN = 32
);
    logic [N-1:0]    req_valid;
    logic [N*8-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            sel;
    logic            enable;
    logic            write;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;

    modport master (
        input  req_valid, req_data, rdata,
        output req_ready, sel, enable, write, addr, wdata
    );

    modport slave (
        output req_valid, req_data, rdata,
        input  req_ready, sel, enable, write, addr, wdata
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at pointer p and wraps modulo N.
// The pointer moves to winner+1 on every accepted grant.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr;

    // (base + step) mod N, valid for step < N
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Scan farthest-first so the requester nearest the pointer overwrites the rest
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_inc(ptr, k)]) begin
                grant                  = '0;
                grant[wrap_inc(ptr, k)] = 1'b1;
                idx                    = wrap_inc(ptr, k);
            end
        end
    end

    // Pointer advances past the winner on each accept
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= wrap_inc(idx, 1);
        end
    end

endmodule

// File: rtl/riscv_uart_tx_sched.sv
// Shares one riscv_uart transmitter among N byte requesters: round-robin
// accept, one TX data write, then status polls until the transmitter is
// idle or the poll budget runs out (sticky err).
module riscv_uart_tx_sched
    import riscv_uart_pkg::*;
#(
    parameter int N       = 2,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   err_clr,
    output logic                   busy,
    output logic                   err,
    riscv_uart_tx_sched_if.master  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(N);

    tx_sched_state_t state;
    logic [CW-1:0]   poll_cnt;
    logic [N-1:0]    grant;
    logic [IW-1:0]   gidx;
    logic            accept;
    logic            unused_rdata;

    // Only the busy bit of the status word matters
    assign unused_rdata = ^bus.rdata;

    // Grant is one-hot over valid requesters, so any valid in IDLE is an accept
    assign accept        = (state == ST_IDLE) && !rst && (|bus.req_valid);
    assign bus.req_ready = accept ? grant : '0;

    rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (accept),
        .grant   (grant),
        .idx     (gidx)
    );

    // FSM with registered bus drive: outputs are loaded for the state being
    // entered. The accepted byte goes straight into wdata, which doubles as
    // the data latch because it is only needed during the WRITE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            poll_cnt   <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            bus.sel    <= 1'b0;
            bus.enable <= 1'b0;
            bus.write  <= 1'b0;
            bus.addr   <= '0;
            bus.wdata  <= '0;
        end else begin
            bus.sel    <= 1'b0;
            bus.enable <= 1'b0;
            bus.write  <= 1'b0;
            bus.addr   <= '0;
            bus.wdata  <= '0;
            if (err_clr) err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        poll_cnt   <= '0;
                        state      <= ST_WRITE;
                        busy       <= 1'b1;
                        bus.sel    <= 1'b1;
                        bus.enable <= 1'b1;
                        bus.write  <= 1'b1;
                        bus.addr   <= XLEN'(UART_TX_ADDR);
                        bus.wdata  <= XLEN'(bus.req_data[8*int'(gidx) +: 8]);
                    end
                end
                ST_WRITE: begin
                    state      <= ST_POLL;
                    bus.sel    <= 1'b1;
                    bus.enable <= 1'b1;
                    bus.addr   <= XLEN'(UART_STAT_ADDR);
                end
                ST_POLL: begin
                    poll_cnt <= poll_cnt + 1'b1;
                    state    <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (!bus.rdata[TX_BUSY_BIT]) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (poll_cnt == CW'(TIMEOUT)) begin
                        // Timeout beats a same-cycle err_clr; the written byte is abandoned
                        err   <= 1'b1;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state      <= ST_POLL;
                        bus.sel    <= 1'b1;
                        bus.enable <= 1'b1;
                        bus.addr   <= XLEN'(UART_STAT_ADDR);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/riscv_uart_tx_sched.md
# riscv_uart_tx_sched

Transmit scheduler that shares the `riscv_uart` peripheral between N byte-stream requesters, such as the core console path and a debug/trace source. It arbitrates round-robin among the requesters. For each granted byte it drives the UART's single-cycle register bus: one write to the TX data register, then status polls until the transmitter is idle. It sits between the requesters and the `riscv_uart` bus port. Polls that never see idle are bounded by a timeout, which raises a sticky error flag.

## Interface
- `N`, 2: number of requesters, range 2..8.
- `XLEN`, 32: bus data and address width.
- `TIMEOUT`, 65535: maximum status polls per byte before abort, minimum 1.
- `clk` in 1: clock. Everything is sampled on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in N: requester i has a byte pending.
- `req_data` in N*8: byte of requester i, in bits [8i+7:8i].
- `req_ready` out N: one-hot accept. A byte transfers when `req_valid[i] & req_ready[i]`.
- `busy` out 1: scheduler is not in IDLE.
- `err` out 1: sticky flag, set when a status-poll timeout occurs.
- `err_clr` in 1: clears `err`.
- `sel`, `enable`, `write` out 1 each: UART bus strobes. An access lasts exactly one cycle.
- `addr` out XLEN: UART register address.
- `wdata` out XLEN: UART write data.
- `rdata` in XLEN: UART read data. It is sampled in the cycle after a read strobe.

## Operation
- FSM states: IDLE, WRITE, POLL, CHECK.
- **IDLE**
  - If any `req_valid` is high, assert `req_ready[g]` combinationally for the round-robin winner g.
  - Latch `req_data[g]`, clear the poll counter, and move to WRITE.
  - With no valid requester, stay in IDLE.
- **Round-robin rule**
  - Search starts at pointer p, then p+1, and so on, wrapping modulo N.
  - On each accept, p becomes g+1, which wraps to 0 when g = N-1.
  - p resets to 0.
- **WRITE**
  - Drive `sel=enable=write=1`, `addr=UART_TX_ADDR`, `wdata={XLEN-8 zeros, byte}` for one cycle.
  - Move to POLL.
- **POLL**
  - Drive `sel=enable=1`, `write=0`, `addr=UART_STAT_ADDR` for one cycle.
  - Increment the poll counter and move to CHECK.
- **CHECK**
  - Drive all strobes low and sample `rdata[TX_BUSY_BIT]`.
  - If the bit is 0, go to IDLE.
  - Else, if the poll counter equals TIMEOUT, set `err` and go to IDLE. The byte is dropped after it was written.
  - Otherwise go back to POLL.
- **Outputs outside WRITE/POLL:** `sel`, `enable`, `write`, `addr` and `wdata` are all 0.
- **Poll counter width:** $clog2(TIMEOUT+1). It never wraps, because the TIMEOUT compare happens first.
- **`err`**
  - Set by a timeout, cleared by `err_clr`.
  - If a timeout and `err_clr` occur in the same cycle, set wins.
  - An active `err` does not stall scheduling.
- **Requester rules**
  - A requester must hold `req_valid` and its data stable until accepted.
  - `req_valid` dropping without an accept is legal. That requester is simply not granted.
- **Reset, including mid-operation**
  - FSM returns to IDLE, p=0, counter=0, `err=0`.
  - All outputs go to 0: `req_ready`, `busy`, bus strobes, `addr` and `wdata`.
  - A byte in flight is lost.
  - `req_ready` is 0 during any cycle in which `rst` is high.

## Timing
- Accept to TX write: the write strobe is on the cycle after the accept edge.
- Minimum service time is 4 cycles per byte: IDLE, WRITE, POLL, CHECK with rdata idle on the first poll.
- Each additional busy poll adds 2 cycles.
- Back-to-back requests: the next accept happens in the IDLE cycle right after CHECK. No dead cycle is inserted.
- `busy` is registered from the state and is high from the cycle after an accept until CHECK exits.

## Structure
- **Package `riscv_uart_pkg`**
  - `UART_TX_ADDR = 12'h004`, `UART_STAT_ADDR = 12'h008`, `TX_BUSY_BIT = 0`.
  - FSM state enum `tx_sched_state_t`.
  - `riscv_uart` imports the same package so register addresses stay in one place.
- **Sub-module `rr_arbiter`** (parameter N)
  - Inputs: request vector, `advance` strobe, `clk`, `rst`.
  - Outputs: one-hot grant and the encoded grant index.
  - Owns pointer p.
- **Top level** holds the FSM, the data latch, the poll counter, the `err` flag and the bus drive.

## Test plan
- **Single byte:** req0 presents 0xA5 and rdata busy bit is 0 → accept in cycle 0; cycle 1 has sel=enable=write=1, addr=0x004, wdata=0x000000A5; cycle 2 is a read of 0x008; back in IDLE at cycle 4.
- **Round-robin:** req0=0x11 and req1=0x22 held continuously, rdata idle → accepts alternate 0,1,0,1 every 4 cycles; no grant is repeated while the other requester is valid.
- **Busy polling:** rdata[0]=1 for 3 polls then 0 → exactly 4 read strobes to 0x008, 10 cycles total, `err` stays 0.
- **Timeout:** TIMEOUT=8, rdata[0] stuck at 1 → 8 polls, then `err`=1 and IDLE; the next request is still served; `err_clr` pulse returns `err` to 0; timeout coinciding with `err_clr` leaves `err`=1.
- **Reset mid-poll:** `rst` asserted in POLL → next cycle all strobes 0, `busy`=0, p=0; after release, a request on req1 alone is accepted normally.
- **Boundary:** N=4, requesters 3 and 0 valid with p=3 → grant 3, then 0 (pointer wrap); `req_valid` dropped before accept → no grant, no bus activity.
